// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the seven-segment display path.
package seg_disp_pkg;

    localparam int BCD_DIGITS = 4;
    localparam int BCD_MAX    = 9999;

    typedef enum logic {
        IDLE,
        SHIFT
    } bcd_state_t;

    typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: add 3 to any digit of 5 or more.
module bcd_add3
    import seg_disp_pkg::*;
(
    input  bcd_digit_t n,
    output bcd_digit_t y
);

    assign y = (n >= 4'd5) ? n + 4'd3 : n;

endmodule

// File: rtl/bin_to_bcd_4digit.sv
// Sequential binary-to-BCD converter, one bit per clock, saturating at 9999.
module bin_to_bcd_4digit
    import seg_disp_pkg::*;
#(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    output logic             busy,
    output logic             out_valid,
    output logic [3:0]       bcd_1,
    output logic [3:0]       bcd_2,
    output logic [3:0]       bcd_3,
    output logic [3:0]       bcd_4,
    output logic             ovf
);

    localparam int W  = 16 + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    bcd_state_t     state;
    logic [W-1:0]   work;
    logic [CW-1:0]  cnt;
    logic           ovf_pend;
    logic [13:0]    in14;
    logic           over;
    logic [WIDTH-1:0] op;
    logic [15:0]    fix;
    logic [W-1:0]   nxt;

    assign in14     = 14'(in_value);
    assign over     = in14 > 14'(BCD_MAX);
    assign op       = over ? WIDTH'(BCD_MAX) : in_value;
    assign in_ready = (state == IDLE);
    assign busy     = (state == SHIFT);

    for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .n (work[WIDTH + 4*i +: 4]),
            .y (fix[4*i +: 4])
        );
    end

    // Correct every digit, then shift the whole register left by one.
    assign nxt = {fix[14:0], work[WIDTH-1:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            cnt       <= '0;
            ovf_pend  <= 1'b0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            bcd_1     <= '0;
            bcd_2     <= '0;
            bcd_3     <= '0;
            bcd_4     <= '0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= {16'b0, op};
                        cnt      <= CW'(WIDTH);
                        ovf_pend <= over;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= nxt;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state     <= IDLE;
                        bcd_1     <= nxt[W-1  -: 4];
                        bcd_2     <= nxt[W-5  -: 4];
                        bcd_3     <= nxt[W-9  -: 4];
                        bcd_4     <= nxt[W-13 -: 4];
                        ovf       <= ovf_pend;
                        out_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_4digit.sv
// Directed bench for bin_to_bcd_4digit with WIDTH = 14.
module tb_bin_to_bcd_4digit;

    localparam int WIDTH = 14;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_value = '0;
    logic             busy;
    logic             out_valid;
    logic [3:0]       bcd_1, bcd_2, bcd_3, bcd_4;
    logic             ovf;

    int errors = 0;
    int checks = 0;

    bin_to_bcd_4digit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .busy      (busy),
        .out_valid (out_valid),
        .bcd_1     (bcd_1),
        .bcd_2     (bcd_2),
        .bcd_3     (bcd_3),
        .bcd_4     (bcd_4),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    wire [15:0] digits = {bcd_1, bcd_2, bcd_3, bcd_4};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accept one value, wait for the result, check latency/busy/digits.
    task automatic run(input string tag, input logic [WIDTH-1:0] v,
                       input logic [15:0] exp_d, input logic exp_ovf);
        int n;
        int bc;
        @(negedge clk);
        check({tag, "_rdy"}, in_ready, 1'b1);
        in_valid = 1'b1;
        in_value = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n  = 0;
        bc = busy ? 1 : 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) bc++;
        end
        check({tag, "_lat"}, n, 14);
        check({tag, "_dig"}, digits, exp_d);
        check({tag, "_ovf"}, ovf, exp_ovf);
        check({tag, "_busy"}, bc, 14);
        check({tag, "_rdy2"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, out_valid, 1'b0);
    endtask

    initial begin
        int n;
        int n2;
        int bad;
        int pulses;

        #1;
        check("rst_dig", digits, 16'h0000);
        check("rst_ovf", ovf, 1'b0);
        check("rst_ov", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rdy", in_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run("zero", 14'd0, 16'h0000, 1'b0);
        run("mid", 14'd1234, 16'h1234, 1'b0);
        run("b9999", 14'd9999, 16'h9999, 1'b0);
        run("b10000", 14'd10000, 16'h9999, 1'b1);
        run("b16383", 14'd16383, 16'h9999, 1'b1);
        run("one", 14'd1, 16'h0001, 1'b0);

        // Reset mid-conversion, with nonzero digits held beforehand.
        run("pre", 14'd8765, 16'h8765, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_value = 14'd1234;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_dig", digits, 16'h0000);
        check("mr_ovf", ovf, 1'b0);
        check("mr_ov", out_valid, 1'b0);
        check("mr_busy", busy, 1'b0);
        check("mr_rdy", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check("mr_nopulse", pulses, 0);
        check("mr_rdy2", in_ready, 1'b1);

        // Back-to-back with in_valid held high.
        @(negedge clk);
        in_valid = 1'b1;
        in_value = 14'd42;
        @(posedge clk);
        #1;
        in_value = 14'd907;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bb_lat1", n, 14);
        check("bb_dig1", digits, 16'h0042);
        n2  = 0;
        bad = 0;
        do begin
            @(posedge clk);
            #1;
            n2++;
            if (!out_valid && digits !== 16'h0042) bad++;
        end while (!out_valid && n2 < 40);
        in_valid = 1'b0;
        check("bb_gap", n2, 15);
        check("bb_hold", bad, 0);
        check("bb_dig2", digits, 16'h0907);
        check("bb_ovf", ovf, 1'b0);
        repeat (3) @(posedge clk);

        // in_valid pulse during SHIFT must be ignored.
        @(negedge clk);
        in_valid = 1'b1;
        in_value = 14'd321;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("bi_busy", busy, 1'b1);
        check("bi_rdy", in_ready, 1'b0);
        in_valid = 1'b1;
        in_value = 14'd5555;
        @(negedge clk);
        in_valid = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check("bi_pulses", pulses, 1);
        check("bi_dig", digits, 16'h0321);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
